// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Package     : synth_pkg
// Description : Shared constants and types for the synthesizer voice path.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int VOICES   = 8;
    localparam int FRAC_W   = 20;
    localparam int NOTE_MAX = 95;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [6:0] note;
        logic       busy;
        logic [2:0] rank;
    } voice_t;

endpackage
`default_nettype wire

// File: rtl/note_to_frequency.sv
`default_nettype none
// ============================================================================
// Module      : note_to_frequency
// Description : Registered 96-entry MIDI note to Q11.20 Hz frequency ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module note_to_frequency (
    input  logic        clk,
    input  logic [6:0]  i_note,
    output logic [31:0] o_freq
);

    localparam int ENTRIES = 96;

    // Equal temperament around A4 = 440 Hz, rounded to nearest Q.20 step.
    function automatic logic [31:0] freq_q20(input int n);
        real f;
        f = 440.0 * (2.0 ** ((n - 69) / 12.0)) * 1048576.0;
        return $rtoi(f + 0.5);
    endfunction

    logic [31:0] w_rom [ENTRIES];

    for (genvar g = 0; g < ENTRIES; g++) begin : g_rom
        localparam logic [31:0] C_FREQ = freq_q20(g);
        assign w_rom[g] = C_FREQ;
    end

    always_ff @(posedge clk) begin
        o_freq <= (i_note < 7'(ENTRIES)) ? w_rom[i_note] : '0;
    end

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : voice_allocator
// Description : 8-voice note scheduler with LRU voice stealing.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int VOICES    = synth_pkg::VOICES,
    parameter int VEL_SHIFT = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic              ev_note_on,
    input  logic [6:0]        ev_note,
    input  logic [6:0]        ev_velocity,
    input  logic              panic,
    output logic [31:0]       frequencies   [VOICES-1:0],
    output logic [31:0]       voice_volumes [VOICES-1:0],
    output logic [VOICES-1:0] active,
    output logic              stolen
);

    import synth_pkg::*;

    localparam int               IDX_W  = $clog2(VOICES);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(VOICES - 1);

    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_cnt;
    logic [6:0]       r_note, r_vel;
    logic             r_on;
    logic             r_match_hit, r_free_hit;
    logic [IDX_W-1:0] r_match_idx, r_free_idx, r_rank0_idx;
    voice_t           r_voice [VOICES];
    logic [31:0]      w_freq;
    logic             w_accept, w_in_range, w_steal;
    logic [IDX_W-1:0] w_sel;

    note_to_frequency u_rom (
        .clk    (clk),
        .i_note (r_note),
        .o_freq (w_freq)
    );

    assign ev_ready   = (r_state == ST_IDLE);
    assign w_accept   = ev_valid && ev_ready && !panic;
    assign w_in_range = (r_note <= 7'(NOTE_MAX));
    assign w_steal    = !r_match_hit && !r_free_hit;
    assign w_sel      = r_match_hit ? r_match_idx : (r_free_hit ? r_free_idx : r_rank0_idx);

    for (genvar g = 0; g < VOICES; g++) begin : g_active
        assign active[g] = r_voice[g].busy;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_SCAN;
            ST_SCAN:   if (r_cnt == C_LAST) w_next = ST_LOOKUP;
            ST_LOOKUP: w_next = ST_WRITE;
            ST_WRITE:  w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (panic) w_next = ST_IDLE;
    end

    // Event latch and one-voice-per-cycle scan.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_note      <= '0;
            r_vel       <= '0;
            r_on        <= 1'b0;
            r_match_hit <= 1'b0;
            r_free_hit  <= 1'b0;
            r_match_idx <= '0;
            r_free_idx  <= '0;
            r_rank0_idx <= '0;
        end else if (w_accept) begin
            r_note      <= ev_note;
            r_vel       <= ev_velocity;
            r_on        <= ev_note_on && (ev_velocity != 7'd0);
            r_cnt       <= '0;
            r_match_hit <= 1'b0;
            r_free_hit  <= 1'b0;
        end else if (r_state == ST_SCAN) begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_match_hit && r_voice[r_cnt].busy && (r_voice[r_cnt].note == r_note)) begin
                r_match_hit <= 1'b1;
                r_match_idx <= r_cnt;
            end
            if (!r_free_hit && !r_voice[r_cnt].busy) begin
                r_free_hit <= 1'b1;
                r_free_idx <= r_cnt;
            end
            if (r_voice[r_cnt].rank == 3'd0) r_rank0_idx <= r_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stolen <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                frequencies[i]   <= 32'(55) << FRAC_W;
                voice_volumes[i] <= '0;
                r_voice[i]       <= '{note: 7'd0, busy: 1'b0, rank: 3'(i)};
            end
        end else begin
            stolen <= 1'b0;
            if (panic) begin
                for (int i = 0; i < VOICES; i++) begin
                    voice_volumes[i] <= '0;
                    r_voice[i].busy  <= 1'b0;
                end
            end else if ((r_state == ST_WRITE) && w_in_range) begin
                if (r_on) begin
                    frequencies[w_sel]   <= w_freq;
                    voice_volumes[w_sel] <= 32'(r_vel) << VEL_SHIFT;
                    r_voice[w_sel].note  <= r_note;
                    r_voice[w_sel].busy  <= 1'b1;
                    stolen               <= w_steal;
                    // Chosen voice becomes newest; voices newer than it age by one.
                    for (int i = 0; i < VOICES; i++) begin
                        if (IDX_W'(i) == w_sel)
                            r_voice[i].rank <= 3'd7;
                        else if (r_voice[i].rank > r_voice[w_sel].rank)
                            r_voice[i].rank <= r_voice[i].rank - 3'd1;
                    end
                end else if (r_match_hit) begin
                    voice_volumes[r_match_idx] <= '0;
                    r_voice[r_match_idx].busy  <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
